mem_burst_in: RTL and testbench

Burst writer, the write-side counterpart of the memory burst reader. It accepts a stream of words over a simple valid/ready interface and writes each word into a memory block (single-cycle write port: block[addr] <= data_out when we) at consecutive addresses, starting at a programmed base address. A burst runs for a programmed length. Used by the Ethernet datapath to move received words into buffer RAM.

---
 rtl/mem_burst_in_if.sv | 30 +++
 rtl/mem_burst_in.sv | 100 ++++++++++
 tb/tb_mem_burst_in.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_burst_in_if.sv
// Burst-writer bus bundle: burst control, inbound valid/ready stream and
// the single-cycle memory write port.
`timescale 1ns/1ps
interface mem_burst_in_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   len;
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   count;
   logic [DATA_W-1:0] data_in;
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_out;
   logic              we;

   modport master (
      output start_addr, len, start, data_in, valid,
      input  busy, done, count, ready, addr, data_out, we
   );

   modport slave (
      input  start_addr, len, start, data_in, valid,
      output busy, done, count, ready, addr, data_out, we
   );
endinterface

// File: rtl/mem_burst_in.sv
// Burst writer: takes words from a valid/ready stream and writes them to
// consecutive memory addresses from a programmed base for a programmed length.
`timescale 1ns/1ps
module mem_burst_in #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   mem_burst_in_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t            state_q;
   state_t            state_d;
   logic              load;
   logic              xfer;

   logic              ready_q;
   logic              busy_q;
   logic              done_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W-1:0] next_addr_q;
   logic [ADDR_W:0]   remaining_q;

   assign load = (state_q == IDLE) && bus.start;
   // ready_q is only ever high in BURST, so xfer never fires elsewhere
   assign xfer = bus.valid && ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = (bus.len == '0) ? DONE : BURST;
            end
         end
         BURST: begin
            if (xfer && (remaining_q == (ADDR_W+1)'(1))) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status flags are decoded from the next state so they line up with state_q
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         count_q     <= '0;
         next_addr_q <= '0;
         remaining_q <= '0;
      end else begin
         ready_q <= (state_d == BURST);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         we_q    <= xfer;
         if (load) begin
            next_addr_q <= bus.start_addr;
            remaining_q <= bus.len;
            count_q     <= '0;
         end
         if (xfer) begin
            addr_q      <= next_addr_q;
            data_q      <= bus.data_in;
            next_addr_q <= next_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - (ADDR_W+1)'(1);
            count_q     <= count_q + (ADDR_W+1)'(1);
         end
      end
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.we       = we_q;
   assign bus.addr     = addr_q;
   assign bus.data_out = data_q;
   assign bus.count    = count_q;

endmodule

// File: tb/tb_mem_burst_in.sv
// Randomized bench for mem_burst_in, checked cycle by cycle against a
// transaction-level model of where each accepted word must land.
`timescale 1ns/1ps
module tb_mem_burst_in;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [ADDR_W-1:0] exp_addr = '0;
   logic [DATA_W-1:0] exp_data = '0;
   bit                seen [256];

   mem_burst_in_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_burst_in #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag, input int n);
      check({tag, " busy"},  64'(bus.busy),  0);
      check({tag, " done"},  64'(bus.done),  0);
      check({tag, " ready"}, 64'(bus.ready), 0);
      check({tag, " we"},    64'(bus.we),    0);
      check({tag, " count"}, 64'(bus.count), 64'(n));
   endtask

   // One burst: model tracks words accepted; word k lands at base+k mod 2^ADDR_W
   task automatic run_burst(input logic [ADDR_W-1:0] base, input int n, input int vpct,
                            input bit mid_start, input int rst_after, input bit done_start);
      int acc = 0;
      bit hs_prev = 1'b0;
      bit in_done;
      @(negedge clk);
      bus.start_addr = base;
      bus.len        = (ADDR_W+1)'(n);
      bus.start      = 1'b1;
      bus.valid      = 1'b0;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.we) seen[bus.addr] = 1'b1;
         if (rst_after >= 0 && acc == rst_after) begin
            bus.valid = 1'b0;
            rst = 1'b1;
            #1;
            check("rst busy", 64'(bus.busy), 0);
            check("rst we", 64'(bus.we), 0);
            check("rst ready", 64'(bus.ready), 0);
            check("rst addr", 64'(bus.addr), 0);
            check("rst data", 64'(bus.data_out), 0);
            check("rst count", 64'(bus.count), 0);
            @(negedge clk);
            rst = 1'b0;
            exp_addr = '0;
            exp_data = '0;
            @(negedge clk);
            check_idle("post-rst", 0);
            return;
         end
         in_done = (acc == n);
         check("ready", 64'(bus.ready), 64'(!in_done));
         check("busy", 64'(bus.busy), 1);
         check("done", 64'(bus.done), 64'(in_done));
         check("we", 64'(bus.we), 64'(hs_prev));
         check("addr", 64'(bus.addr), 64'(exp_addr));
         check("data_out", 64'(bus.data_out), 64'(exp_data));
         check("count", 64'(bus.count), 64'(acc));
         if (in_done) begin
            if (done_start) begin
               bus.start      = 1'b1;
               bus.start_addr = 8'h55;
               bus.len        = 9'd3;
            end
            @(negedge clk);
            bus.start = 1'b0;
            check_idle("after done", n);
            return;
         end
         if (mid_start && cyc == 2) begin
            bus.start      = 1'b1;
            bus.start_addr = 8'h80;
            bus.len        = 9'd7;
         end
         bus.valid   = ($urandom_range(99) < vpct);
         bus.data_in = $urandom;
         hs_prev = bus.valid;
         if (bus.valid) begin
            exp_addr = ADDR_W'(int'(base) + acc);
            exp_data = bus.data_in;
            acc++;
         end
      end
      check("burst timeout", 1, 0);
   endtask

   initial begin
      int nseen;
      bus.start_addr = '0;
      bus.len        = '0;
      bus.start      = 1'b0;
      bus.data_in    = '0;
      bus.valid      = 1'b0;
      #1;
      check("reset busy", 64'(bus.busy), 0);
      check("reset addr", 64'(bus.addr), 0);
      check("reset data", 64'(bus.data_out), 0);
      check_idle("reset", 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_burst(8'h10, 4, 100, 1'b0, -1, 1'b0);
      run_burst(8'h20, 3, 40, 1'b0, -1, 1'b0);
      run_burst(8'hFE, 4, 100, 1'b0, -1, 1'b0);
      run_burst(8'h33, 0, 100, 1'b0, -1, 1'b0);
      run_burst(8'h10, 4, 100, 1'b1, -1, 1'b1);
      run_burst(8'h30, 5, 100, 1'b0, 2, 1'b0);
      run_burst(8'h40, 5, 70, 1'b0, -1, 1'b0);

      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      run_burst(8'h05, 256, 100, 1'b0, -1, 1'b0);
      nseen = 0;
      for (int i = 0; i < 256; i++) nseen += int'(seen[i]);
      check("full coverage", 64'(nseen), 256);

      for (int i = 0; i < 6; i++) begin
         run_burst(ADDR_W'($urandom), int'($urandom_range(1, 20)), 60, 1'b0, -1, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
